// File: rtl/demod_pkg.sv
// demod_pkg: constants, ceil-log2 helper and FSM state shared across the demodulator datapath
package demod_pkg;
    localparam int CORR_W = 24;
    localparam int SPS = 32;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    typedef enum logic [1:0] {ACQ, EVAL, TRACK} demod_state_t;
endpackage

// File: rtl/symbol_slicer_if.sv
// symbol_slicer_if: correlation stream in, sliced bits and lock status out
interface symbol_slicer_if #(
    parameter int W = demod_pkg::CORR_W,
    parameter int PW = demod_pkg::clog2(demod_pkg::SPS)
);
    import demod_pkg::*;
    logic [W-1:0] corr;
    logic corr_valid;
    logic bit_out;
    logic bit_valid;
    logic locked;
    logic [PW-1:0] lock_phase;
    logic [W-1:0] threshold;
    modport master (output corr, corr_valid, input bit_out, bit_valid, locked, lock_phase, threshold);
    modport slave (input corr, corr_valid, output bit_out, bit_valid, locked, lock_phase, threshold);
endinterface

// File: rtl/acq_stats.sv
// acq_stats: max/min/peak-phase tracker over one acquisition window
module acq_stats #(
    parameter int W = demod_pkg::CORR_W,
    parameter int PW = demod_pkg::clog2(demod_pkg::SPS),
    parameter int WIN = 4 * demod_pkg::SPS
)(
    input  logic          clk_fast,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [W-1:0]  corr,
    input  logic [PW-1:0] ph,
    output logic [W-1:0]  max_v,
    output logic [W-1:0]  min_v,
    output logic [PW-1:0] pmax,
    output logic          done
);
    import demod_pkg::*;
    localparam int WC_W = clog2(WIN);
    logic [WC_W-1:0] wc;
    assign done = en && wc == WC_W'(WIN - 1);
    // strict compares keep the first occurrence on ties
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            max_v <= '0;
            min_v <= '1;
            pmax <= '0;
            wc <= '0;
        end else if (clr) begin
            max_v <= '0;
            min_v <= '1;
            wc <= '0;
        end else if (en) begin
            if (corr > max_v) begin
                max_v <= corr;
                pmax <= ph;
            end
            if (corr < min_v) min_v <= corr;
            wc <= wc + 1'b1;
        end
    end
endmodule

// File: rtl/symbol_slicer.sv
// symbol_slicer: acquires symbol phase and threshold from window statistics, then slices one bit per symbol
module symbol_slicer #(
    parameter int CORR_W = demod_pkg::CORR_W,
    parameter int SPS = demod_pkg::SPS,
    parameter int ACQ_SYMBOLS = 4,
    parameter logic [CORR_W-1:0] MIN_SWING = 'h001000,
    parameter logic [CORR_W-1:0] MIN_MARGIN = 'h000400,
    parameter int LOSS_COUNT = 3
)(
    input logic clk_fast,
    input logic rst,
    symbol_slicer_if.slave bus
);
    import demod_pkg::*;
    localparam int PW = clog2(SPS);
    localparam int MW = clog2(LOSS_COUNT + 1);
    demod_state_t state, state_nxt;
    logic [PW-1:0] ph, pmax;
    logic [MW-1:0] miss, miss_nxt;
    logic [CORR_W-1:0] max_v, min_v, thr, margin;
    logic [CORR_W:0] sum;
    logic done, swing_ok, hit, bit_now, loss;

    // statistics are held cleared outside ACQ so every entry starts a fresh window
    acq_stats #(.W(CORR_W), .PW(PW), .WIN(ACQ_SYMBOLS * SPS)) u_stats (
        .clk_fast(clk_fast),
        .rst(rst),
        .clr(state != ACQ),
        .en(state == ACQ && bus.corr_valid),
        .corr(bus.corr),
        .ph(ph),
        .max_v(max_v),
        .min_v(min_v),
        .pmax(pmax),
        .done(done)
    );

    always_comb begin
        sum = {1'b0, max_v} + {1'b0, min_v};
        thr = CORR_W'(sum >> 1);
        swing_ok = max_v - min_v >= MIN_SWING;
        hit = state == TRACK && bus.corr_valid && ph == bus.lock_phase;
        bit_now = bus.corr >= bus.threshold;
        margin = bit_now ? bus.corr - bus.threshold : bus.threshold - bus.corr;
        miss_nxt = state != TRACK ? '0 : hit ? (margin < MIN_MARGIN ? miss + 1'b1 : '0) : miss;
        loss = hit && miss_nxt == MW'(LOSS_COUNT);
        state_nxt = state == ACQ ? (done ? EVAL : ACQ) :
                    state == EVAL ? (swing_ok ? TRACK : ACQ) :
                    (loss ? ACQ : TRACK);
    end

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            state <= ACQ;
            ph <= '0;
            miss <= '0;
            bus.bit_out <= 1'b0;
            bus.bit_valid <= 1'b0;
            bus.locked <= 1'b0;
            bus.lock_phase <= '0;
            bus.threshold <= '0;
        end else begin
            state <= state_nxt;
            miss <= miss_nxt;
            if (bus.corr_valid) ph <= ph + 1'b1;
            bus.bit_valid <= hit;
            if (hit) bus.bit_out <= bit_now;
            bus.locked <= state_nxt == TRACK;
            if (state == EVAL && swing_ok) begin
                bus.lock_phase <= pmax;
                bus.threshold <= thr;
            end
        end
    end
endmodule

// File: tb/tb_symbol_slicer.sv
// tb_symbol_slicer: scenario tasks plus randomized traffic against a queue-based window model
module tb_symbol_slicer;
    localparam int SPS = 32;
    localparam int WIN = 128;
    logic clk_fast = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk_fast = ~clk_fast;

    symbol_slicer_if bus();
    symbol_slicer dut (.clk_fast(clk_fast), .rst(rst), .bus(bus));

    // model: 0 acquiring, 1 evaluating, 2 tracking
    int m_state = 0, mph = 0, m_lock = 0, m_thr = 0, m_miss = 0;
    logic m_bit = 1'b0, m_bv = 1'b0, m_locked = 1'b0;
    int win_v[$];
    int win_p[$];

    always @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            m_state = 0; mph = 0; m_lock = 0; m_thr = 0; m_miss = 0;
            m_bit = 1'b0; m_bv = 1'b0; m_locked = 1'b0;
            win_v.delete(); win_p.delete();
        end else begin
            int c, p, mx, mn, pk;
            logic v;
            c = int'(bus.corr); v = bus.corr_valid; p = mph;
            m_bv = 1'b0;
            if (v) mph = (mph + 1) % SPS;
            if (m_state == 0) begin
                if (v) begin win_v.push_back(c); win_p.push_back(p); end
                if (win_v.size() == WIN) m_state = 1;
            end else if (m_state == 1) begin
                mx = 0; mn = 'hFFFFFF; pk = 0;
                foreach (win_v[i]) begin
                    if (win_v[i] > mx) mx = win_v[i];
                    if (win_v[i] < mn) mn = win_v[i];
                end
                for (int i = WIN - 1; i >= 0; i--) if (win_v[i] == mx) pk = win_p[i];
                if (mx - mn >= 'h1000) begin
                    m_state = 2; m_lock = pk; m_thr = (mx + mn) / 2; m_miss = 0;
                end else m_state = 0;
                win_v.delete(); win_p.delete();
            end else if (v && p == m_lock) begin
                m_bit = c >= m_thr; m_bv = 1'b1;
                m_miss = ((c > m_thr ? c - m_thr : m_thr - c) < 'h400) ? m_miss + 1 : 0;
                if (m_miss == 3) m_state = 0;
            end
            m_locked = m_state == 2;
        end
    end

    task automatic step(input int c, input logic v);
        bus.corr = 24'(c);
        bus.corr_valid = v;
        @(posedge clk_fast);
        #1;
    endtask

    function automatic int pat(input int p, input int pk, input logic b);
        return p == pk ? (b ? 'h030000 : 'h010000) : 'h020000;
    endfunction

    task automatic lock_up(input int pk);
        rst = 1'b0;
        step('h020000, 1'b0);
        rst = 1'b1;
        for (int k = 0; k <= WIN; k++) step(pat(mph, pk, (k / SPS) % 2 == 0), 1'b1);
    endtask

    task automatic test_reset;
        bus.corr = '0;
        bus.corr_valid = 1'b0;
        repeat (2) @(posedge clk_fast);
        #1;
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out got %b want 0", bus.bit_out); end
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got %b want 0", bus.bit_valid); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", bus.locked); end
        checks++; if (bus.lock_phase !== 5'd0) begin errors++; $display("FAIL reset_lock_phase got %0d want 0", bus.lock_phase); end
        checks++; if (bus.threshold !== 24'h0) begin errors++; $display("FAIL reset_threshold got %h want 000000", bus.threshold); end
    endtask

    task automatic test_lock;
        logic sym[3] = '{1'b1, 1'b1, 1'b0};
        logic got[$];
        rst = 1'b1;
        for (int k = 0; k < WIN; k++) step(pat(mph, 7, (k / SPS) % 2 == 0), 1'b1);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_before_eval got %b want 0", bus.locked); end
        step(pat(mph, 7, 1'b0), 1'b1);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_locked got %b want 1", bus.locked); end
        checks++; if (bus.lock_phase !== 5'd7) begin errors++; $display("FAIL lock_phase got %0d want 7", bus.lock_phase); end
        checks++; if (bus.threshold !== 24'h020000) begin errors++; $display("FAIL lock_threshold got %h want 020000", bus.threshold); end
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < SPS; i++) begin
                step(pat(mph, 7, sym[s]), 1'b1);
                checks++; if (bus.bit_valid !== m_bv) begin errors++; $display("FAIL lock_pulse got %b want %b", bus.bit_valid, m_bv); end
                if (bus.bit_valid) got.push_back(bus.bit_out);
            end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL lock_pulse_count got %0d want 3", got.size()); end
        foreach (got[i]) begin
            checks++; if (i < 3 && got[i] !== sym[i]) begin errors++; $display("FAIL lock_bit%0d got %b want %b", i, got[i], sym[i]); end
        end
    endtask

    task automatic test_loss;
        int vals[6] = '{'h020100, 'h020100, 'h020400, 'h020100, 'h020100, 'h020100};
        logic exp_lock[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int n = 0;
        for (int s = 0; s < 6; s++)
            for (int i = 0; i < SPS; i++) begin
                step(mph == 7 ? vals[s] : 'h020000, 1'b1);
                checks++; if (bus.bit_valid !== m_bv) begin errors++; $display("FAIL loss_pulse got %b want %b", bus.bit_valid, m_bv); end
                if (bus.bit_valid && n < 6) begin
                    checks++; if (bus.bit_out !== 1'b1) begin errors++; $display("FAIL loss_bit%0d got %b want 1", n, bus.bit_out); end
                    checks++; if (bus.locked !== exp_lock[n]) begin errors++; $display("FAIL loss_locked%0d got %b want %b", n, bus.locked, exp_lock[n]); end
                    n++;
                end
            end
        checks++; if (n != 6) begin errors++; $display("FAIL loss_pulse_count got %0d want 6", n); end
        checks++; if (bus.threshold !== 24'h020000) begin errors++; $display("FAIL loss_threshold_hold got %h want 020000", bus.threshold); end
    endtask

    task automatic test_stall;
        int n = 0;
        lock_up(7);
        while (mph != 7) step(pat(mph, 7, 1'b1), 1'b1);
        repeat (10) begin
            step('h030000, 1'b0);
            checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse got %b want 0", bus.bit_valid); end
        end
        step('h010000, 1'b1);
        checks++; if (bus.bit_valid !== 1'b1) begin errors++; $display("FAIL stall_resume_pulse got %b want 1", bus.bit_valid); end
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL stall_resume_bit got %b want 0", bus.bit_out); end
        for (int i = 0; i < SPS; i++) begin
            step(pat(mph, 7, 1'b1), 1'b1);
            if (bus.bit_valid) n++;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL stall_realign got %0d pulses want 1", n); end
    endtask

    task automatic test_tie;
        rst = 1'b0;
        step('h020000, 1'b0);
        rst = 1'b1;
        for (int k = 0; k <= WIN; k++)
            step((k < SPS && (mph == 3 || mph == 9)) ? 'h030000 : (k < SPS && mph == 20) ? 'h010000 : 'h020000, 1'b1);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL tie_locked got %b want 1", bus.locked); end
        checks++; if (bus.lock_phase !== 5'd3) begin errors++; $display("FAIL tie_phase got %0d want 3", bus.lock_phase); end
    endtask

    task automatic test_low_swing;
        int early = 0;
        rst = 1'b0;
        step('h020000, 1'b0);
        rst = 1'b1;
        // two windows with swing 0xFFF, then one with swing exactly 0x1000
        for (int k = 0; k < 2 * (WIN + 1); k++) begin
            step(mph == 7 ? ((k / SPS) % 2 == 0 ? 'h0207FF : 'h01F800) : 'h020000, 1'b1);
            if (bus.locked !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL low_swing_locked got %0d locked cycles want 0", early); end
        for (int k = 0; k < WIN; k++) step(mph == 7 ? ((k / SPS) % 2 == 0 ? 'h020800 : 'h01F800) : 'h020000, 1'b1);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL low_swing_eval_cycle got %b want 0", bus.locked); end
        step('h020000, 1'b1);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL low_swing_edge_lock got %b want 1", bus.locked); end
        checks++; if (bus.threshold !== 24'h020000) begin errors++; $display("FAIL low_swing_threshold got %h want 020000", bus.threshold); end
    endtask

    task automatic test_reset_mid_track;
        lock_up(7);
        repeat (40) step(pat(mph, 7, 1'b1), 1'b1);
        rst = 1'b0;
        #1;
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL rst_mid_bit_out got %b want 0", bus.bit_out); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_mid_locked got %b want 0", bus.locked); end
        checks++; if (bus.lock_phase !== 5'd0) begin errors++; $display("FAIL rst_mid_lock_phase got %0d want 0", bus.lock_phase); end
        checks++; if (bus.threshold !== 24'h0) begin errors++; $display("FAIL rst_mid_threshold got %h want 000000", bus.threshold); end
        step('h020000, 1'b1);
        rst = 1'b1;
        for (int k = 0; k < WIN; k++) step(pat(mph, 12, (k / SPS) % 2 == 1), 1'b1);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_mid_relock_early got %b want 0", bus.locked); end
        step('h020000, 1'b1);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL rst_mid_relock got %b want 1", bus.locked); end
        checks++; if (bus.lock_phase !== 5'd12) begin errors++; $display("FAIL rst_mid_relock_phase got %0d want 12", bus.lock_phase); end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            int pk, amp, base, c;
            pk = $urandom_range(0, SPS - 1);
            amp = $urandom_range('h200, 'h3000);
            base = $urandom_range('h100000, 'h800000);
            rst = 1'b0;
            step(base, 1'b0);
            rst = 1'b1;
            for (int i = 0; i < 600; i++) begin
                if (mph != pk) c = base + $urandom_range(0, amp / 2);
                else if ($urandom_range(0, 3) == 0) c = base + $urandom_range(0, 'h500);
                else c = $urandom_range(0, 1) ? base + amp : base - amp;
                step(c, $urandom_range(0, 9) != 0);
                checks++; if (bus.bit_valid !== m_bv) begin errors++; $display("FAIL rand_bit_valid got %b want %b", bus.bit_valid, m_bv); end
                checks++; if (bus.bit_out !== m_bit) begin errors++; $display("FAIL rand_bit_out got %b want %b", bus.bit_out, m_bit); end
                checks++; if (bus.locked !== m_locked) begin errors++; $display("FAIL rand_locked got %b want %b", bus.locked, m_locked); end
                checks++; if (bus.lock_phase !== 5'(m_lock)) begin errors++; $display("FAIL rand_lock_phase got %0d want %0d", bus.lock_phase, m_lock); end
                checks++; if (bus.threshold !== 24'(m_thr)) begin errors++; $display("FAIL rand_threshold got %h want %h", bus.threshold, m_thr); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_lock;
        test_loss;
        test_stall;
        test_tie;
        test_low_swing;
        test_reset_mid_track;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
